// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches over a req/ready handshake, absorbs decode stalls in a one-entry
// skid buffer and applies decode-stage redirects, dropping wrong-path words.
// Optional build macro: FETCH_STATS_EN adds stat_fetched / stat_bubbles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | request outstanding at pc_F, IF/ID loads when data returns
// BUFFER  | word at pc_F parked in skid while decode is stalled
// DISCARD | wrong-path request still outstanding, target parked in target_r
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        pc_src_D,
    input  logic [31:0] jump_address_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction_D,
    output logic [31:0] pc_plus_four_D,
    output logic        valid_D,
    output logic [31:0] pc_F
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_bubbles
`endif
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        BUFFER  = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] target_r, target_nxt;
    logic [31:0] skid, skid_nxt;
    logic        ifid_load;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign redirect  = pc_src_D & valid_D & ~stall_D;
    assign target    = {jump_address_D[31:2], 2'b00};
    assign pc_inc    = pc_F + 32'd4;
    assign imem_req  = ~reset & (state != BUFFER);
    assign imem_addr = pc_F;

    // Next-state, next-PC and IF/ID load decision; ifid_load with
    // ifid_valid=0 and zero payload is the bubble encoding.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_F;
        target_nxt = target_r;
        skid_nxt   = skid;
        ifid_load  = 1'b0;
        ifid_valid = 1'b0;
        ifid_instr = 32'h0;
        ifid_pc4   = 32'h0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    ifid_load = 1'b1;
                    if (imem_ready) begin
                        pc_nxt = target;
                    end else begin
                        target_nxt = target;
                        state_nxt  = DISCARD;
                    end
                end else if (imem_ready && !stall_D) begin
                    ifid_load  = 1'b1;
                    ifid_valid = 1'b1;
                    ifid_instr = imem_data;
                    ifid_pc4   = pc_inc;
                    pc_nxt     = pc_inc;
                end else if (imem_ready) begin
                    skid_nxt  = imem_data;
                    state_nxt = BUFFER;
                end else if (!stall_D) begin
                    ifid_load = 1'b1;
                end
            end
            BUFFER: begin
                if (!stall_D) begin
                    state_nxt = FETCH;
                    ifid_load = 1'b1;
                    if (redirect) begin
                        pc_nxt   = target;
                        skid_nxt = 32'h0;
                    end else begin
                        ifid_valid = 1'b1;
                        ifid_instr = skid;
                        ifid_pc4   = pc_inc;
                        pc_nxt     = pc_inc;
                    end
                end
            end
            DISCARD: begin
                if (imem_ready) begin
                    pc_nxt    = target_r;
                    state_nxt = FETCH;
                end
                if (!stall_D) begin
                    ifid_load = 1'b1;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // State, PC, skid buffer and IF/ID register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= FETCH;
            pc_F           <= RESET_PC;
            target_r       <= 32'h0;
            skid           <= 32'h0;
            instruction_D  <= 32'h0;
            pc_plus_four_D <= 32'h0;
            valid_D        <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_F     <= pc_nxt;
            target_r <= target_nxt;
            skid     <= skid_nxt;
            if (ifid_load) begin
                instruction_D  <= ifid_instr;
                pc_plus_four_D <= ifid_pc4;
                valid_D        <= ifid_valid;
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Count valid loads and bubble loads into IF/ID; both wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_fetched <= 32'h0;
            stat_bubbles <= 32'h0;
        end else if (ifid_load) begin
            if (ifid_valid) begin
                stat_fetched <= stat_fetched + 32'd1;
            end else begin
                stat_bubbles <= stat_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It feeds the decode stage its `instruction` and `pc_plus_four` inputs.
- Holds the PC and issues requests to a variable-latency instruction memory over a req/ready handshake.
- Honours decode-stage stalls through a one-entry skid buffer.
- Applies branch/jump redirects produced in decode (`pc_src` / `jump_address`), discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (MIPS text segment base).

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_D  input  1  hazard unit: hold IF/ID register contents this cycle
pc_src_D  input  1  decode: taken branch/jump present in decode
jump_address_D  input  32  decode: redirect target
imem_req  output  1  instruction memory request valid
imem_addr  output  32  word-aligned fetch address
imem_ready  input  1  memory: imem_data valid, request complete
imem_data  input  32  fetched instruction word
instruction_D  output  32  IF/ID register: instruction to decode
pc_plus_four_D  output  32  IF/ID register: fetch PC + 4
valid_D  output  1  IF/ID register: 1 = real instruction, 0 = bubble
pc_F  output  32  current fetch PC (debug/trace)

Behaviour:
- Reset (sync, reset=1 at edge):
  - pc_F=RESET_PC, state=FETCH.
  - instruction_D=0, pc_plus_four_D=0, valid_D=0, skid buffer=0.
  - imem_req=0 combinationally while reset=1.
- Bubble encoding: any bubble loads instruction_D=32'h0 (sll $0,$0,0 = nop), pc_plus_four_D=0, valid_D=0.
- redirect = pc_src_D & valid_D & !stall_D. Target = {jump_address_D[31:2],2'b00}.
- PC arithmetic: 32-bit, pc_F+4 wraps modulo 2^32.
- imem handshake:
  - imem_req=1 in FETCH and DISCARD; 0 in BUFFER.
  - imem_addr=pc_F, held stable while imem_req & !imem_ready.
  - A transaction completes in the cycle imem_ready=1; zero-wait-state responses (ready in the request cycle) are legal.
  - Requests are never withdrawn once issued.
- State FETCH:
  - If redirect & imem_ready: drop imem_data, pc_F<=target, stay FETCH, IF/ID<=bubble.
  - If redirect & !imem_ready: target_r<=target, go to DISCARD, IF/ID<=bubble.
  - Else if imem_ready & !stall_D: instruction_D<=imem_data, pc_plus_four_D<=pc_F+4, valid_D<=1, pc_F<=pc_F+4.
  - Else if imem_ready & stall_D: skid<=imem_data, go to BUFFER. pc_F and IF/ID unchanged.
  - Else if !imem_ready & !stall_D: IF/ID<=bubble.
  - Else (stall_D, no ready): hold everything.
- State BUFFER (instruction at pc_F is held in skid):
  - If stall_D: hold.
  - If redirect: pc_F<=target, discard skid, IF/ID<=bubble, go to FETCH.
  - Else: IF/ID<=skid / pc_F+4 / valid 1, pc_F<=pc_F+4, go to FETCH.
- State DISCARD (old request still outstanding on the wrong path):
  - On imem_ready: drop data, pc_F<=target_r, go to FETCH.
  - IF/ID<=bubble whenever !stall_D.
  - A redirect cannot occur here because valid_D=0.
- Latency: with zero-wait memory and no stalls, one instruction per cycle. A taken redirect costs exactly one bubble.
- Reset mid-transaction: the memory shares the same reset and abandons the outstanding request; the fetch stage restarts at RESET_PC.

Optional Feature:
FETCH_STATS_EN: when defined, adds two outputs:
- stat_fetched (32): count of IF/ID loads with valid_D=1.
- stat_bubbles (32): count of IF/ID bubble loads.

Both counters reset to 0 and wrap modulo 2^32. Without the macro, the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then zero-wait memory returning addr-as-data → valid_D rises the first cycle after reset release with instruction_D=32'h0040_0000, pc_plus_four_D=32'h0040_0004; successive cycles advance pc_F by 4.
2. Memory with 2 wait states → imem_addr held at 32'h0040_0000 for 3 cycles; 2 bubbles (valid_D=0, instruction_D=0) before the valid load.
3. stall_D=1 for 3 cycles while ready arrives → state BUFFER, imem_req=0, IF/ID unchanged; on release IF/ID gets the buffered word, no instruction lost or duplicated.
4. Redirect to 32'h0040_0100 with 3-wait-state request outstanding → DISCARD; wrong-path data dropped; next imem_addr=32'h0040_0100; exactly 1 wrong-path instruction never reaches valid_D=1.
5. Redirect with jump_address_D=32'h0040_0203 in the same cycle as imem_ready → data dropped, next imem_addr=32'h0040_0200, one bubble.
6. RESET_PC=32'hFFFF_FFFC, zero wait → pc_plus_four_D=0, next imem_addr=0 (wrap); reset asserted mid-stall → all outputs return to reset values next edge.
